// File: rtl/umi_wrr_arbiter_if.sv
// Request/grant bundle between N UMI requesters, the weighted round-robin arbiter and the shared output.
// The slave modport is the arbiter side; the master modport is the parent that drives requests.
interface umi_wrr_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [N*WW-1:0] weights;
    logic [N-1:0]    arbmask;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_eom;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic [SELW-1:0] sel;
    logic            busy;
    logic [N-1:0]    starve;

    modport master (
        output weights, arbmask, req_valid, req_eom, out_ready,
        input  grant, sel, busy, starve
    );

    modport slave (
        input  weights, arbmask, req_valid, req_eom, out_ready,
        output grant, sel, busy, starve
    );
endinterface

// File: rtl/umi_wrr_arbiter.sv
// Packet-aware weighted round-robin arbiter for N UMI requesters; holds the grant until EOM.
// Optional starvation override is enabled by defining UMI_ARB_STARVE_EN.
module umi_wrr_arbiter #(
    parameter int N            = 4,
    parameter int WW           = 4,
    parameter int SW           = 8,
    parameter int STARVE_LIMIT = 64
) (
    input logic               clk,
    input logic               reset,
    umi_wrr_arbiter_if.slave  arb
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_next;
    logic [SELW-1:0] ptr, ptr_next;
    logic [SELW-1:0] lock_sel, lock_sel_next;
    logic [WW-1:0]   pkt_cnt, pkt_cnt_next;

    logic [N-1:0]    cand;
    logic [N-1:0]    starve_vec;
    logic [N-1:0]    grant_c;
    logic [SELW-1:0] win_sel;
    logic [SELW-1:0] sel_c;
    logic            win_found;
    logic            active;
    logic            xfer;
    logic            eom;
    logic [WW-1:0]   base_cnt;
    logic [WW-1:0]   wt_raw;
    logic [WW:0]     wt_eff;
    logic [WW:0]     cnt_inc;

    assign cand = arb.req_valid & ~arb.arbmask;

`ifdef UMI_ARB_STARVE_EN
    logic [SW-1:0] wait_cnt [N];

    // Saturating per-requester wait counters; any transfer by the requester clears its count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (xfer && grant_c[i])
                    wait_cnt[i] <= '0;
                else if (cand[i] && !grant_c[i] && wait_cnt[i] != {SW{1'b1}})
                    wait_cnt[i] <= wait_cnt[i] + SW'(1);
            end
        end
    end

    always_comb begin
        starve_vec = '0;
        for (int i = 0; i < N; i++)
            starve_vec[i] = (int'(wait_cnt[i]) >= STARVE_LIMIT);
    end
`else
    assign starve_vec = '0;
`endif

    // Winner search: first candidate at or above ptr (wrapping), unless a starved candidate exists.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (cand[idx]) begin
                win_found = 1'b1;
                win_sel   = SELW'(idx);
            end
        end
        if (|(cand & starve_vec)) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i] && starve_vec[i]) win_sel = SELW'(i);
            end
        end
    end

    always_comb begin
        sel_c   = (state == LOCKED) ? lock_sel : win_sel;
        active  = (state == LOCKED) ? 1'b1 : win_found;
        grant_c = '0;
        for (int i = 0; i < N; i++)
            grant_c[i] = active && (sel_c == SELW'(i));
        if (!active) sel_c = '0;
    end

    assign xfer = active && arb.req_valid[sel_c] && arb.out_ready;
    assign eom  = arb.req_eom[sel_c];

    // A new contiguous run starts its quota from zero when the winner is not the current ptr holder.
    always_comb begin
        base_cnt = ((state == IDLE) && (win_sel != ptr)) ? '0 : pkt_cnt;
        wt_raw   = arb.weights[int'(sel_c)*WW +: WW];
        wt_eff   = (wt_raw == '0) ? (WW+1)'(1) : {1'b0, wt_raw};
        cnt_inc  = {1'b0, base_cnt} + (WW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            pkt_cnt  <= '0;
            lock_sel <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            pkt_cnt  <= pkt_cnt_next;
            lock_sel <= lock_sel_next;
        end
    end

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        pkt_cnt_next  = pkt_cnt;
        lock_sel_next = lock_sel;
        if (xfer) begin
            if (eom) begin
                state_next = IDLE;
                if (cnt_inc >= wt_eff) begin
                    ptr_next     = (int'(sel_c) == N - 1) ? '0 : sel_c + SELW'(1);
                    pkt_cnt_next = '0;
                end else begin
                    ptr_next     = sel_c;
                    pkt_cnt_next = cnt_inc[WW-1:0];
                end
            end else if (state == IDLE) begin
                state_next    = LOCKED;
                lock_sel_next = sel_c;
                pkt_cnt_next  = base_cnt;
            end
        end
    end

    assign arb.grant  = grant_c;
    assign arb.sel    = sel_c;
    assign arb.busy   = (state == LOCKED);
    assign arb.starve = starve_vec;

endmodule

// File: tb/tb_umi_wrr_arbiter.sv
// Directed self-checking bench for umi_wrr_arbiter; the starvation test runs only when
// UMI_ARB_STARVE_EN is defined.
module tb_umi_wrr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;
`ifdef UMI_ARB_STARVE_EN
    localparam int LIMIT = 8;
`else
    localparam int LIMIT = 64;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    umi_wrr_arbiter_if #(.N(N), .WW(WW)) bus ();

    umi_wrr_arbiter #(.N(N), .WW(WW), .SW(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] onehotToIdx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        if (g[1]) r = 2'd1;
        if (g[2]) r = 2'd2;
        if (g[3]) r = 2'd3;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] eomv,
                                 input logic ready, input logic [3:0] mask);
        @(negedge clk);
        bus.req_valid = valid;
        bus.req_eom   = eomv;
        bus.out_ready = ready;
        bus.arbmask   = mask;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eg,
                               input logic eb, input logic [3:0] es);
        logic [1:0] esel;
        esel = onehotToIdx(eg);
        checks++;
        assert (bus.grant === eg) else begin
            failures++;
            $error("[TB] FAIL %s grant: got %b expected %b", tag, bus.grant, eg);
        end
        checks++;
        assert (bus.sel === esel) else begin
            failures++;
            $error("[TB] FAIL %s sel: got %0d expected %0d", tag, bus.sel, esel);
        end
        checks++;
        assert (bus.busy === eb) else begin
            failures++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, bus.busy, eb);
        end
        checks++;
        assert (bus.starve === es) else begin
            failures++;
            $error("[TB] FAIL %s starve: got %b expected %b", tag, bus.starve, es);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] seq [7];
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.weights = 16'h1111;

        $display("[TB] reset state");
        doReset();
        applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
        checkOutput("reset", 4'b0000, 1'b0, 4'b0000);

        $display("[TB] single-beat rotation");
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0000);
            checkOutput($sformatf("rot%0d", i), seq[i], 1'b0, 4'b0000);
        end

        $display("[TB] weighting req0=3");
        doReset();
        bus.weights = 16'h1113;
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0000);
            checkOutput($sformatf("wgt%0d", i), seq[i], 1'b0, 4'b0000);
        end

        $display("[TB] zero weights act as one");
        doReset();
        bus.weights = 16'h0000;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0000);
            checkOutput($sformatf("w0_%0d", i), seq[i], 1'b0, 4'b0000);
        end

        $display("[TB] packet lock with stall and bubble");
        doReset();
        bus.weights = 16'h1111;
        applyStimulus(4'b0011, 4'b0010, 1'b1, 4'b0000);
        checkOutput("lock_b1", 4'b0001, 1'b0, 4'b0000);
        applyStimulus(4'b0011, 4'b0010, 1'b1, 4'b0000);
        checkOutput("lock_b2", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b0011, 4'b0010, 1'b0, 4'b0000);
        checkOutput("lock_stall1", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b0011, 4'b0010, 1'b0, 4'b0000);
        checkOutput("lock_stall2", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 4'b0000);
        checkOutput("lock_bubble", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b0011, 4'b0010, 1'b1, 4'b0000);
        checkOutput("lock_b3", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b0011, 4'b0011, 1'b1, 4'b0000);
        checkOutput("lock_b4", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 4'b0000);
        checkOutput("lock_next", 4'b0010, 1'b0, 4'b0000);

        $display("[TB] mask mid-packet");
        doReset();
        applyStimulus(4'b1111, 4'b1110, 1'b1, 4'b0000);
        checkOutput("mask_b1", 4'b0001, 1'b0, 4'b0000);
        applyStimulus(4'b1111, 4'b1110, 1'b1, 4'b0001);
        checkOutput("mask_b2", 4'b0001, 1'b1, 4'b0000);
        applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001);
        checkOutput("mask_b3", 4'b0001, 1'b1, 4'b0000);
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1, 4'b0001);
            checkOutput($sformatf("mask_rot%0d", i), seq[i], 1'b0, 4'b0000);
        end

        $display("[TB] reset mid-packet");
        doReset();
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0000);
        checkOutput("rst_b1", 4'b0100, 1'b0, 4'b0000);
        applyStimulus(4'b0110, 4'b0000, 1'b1, 4'b0000);
        reset = 1'b1;
        checkOutput("rst_b2", 4'b0100, 1'b1, 4'b0000);
        applyStimulus(4'b0110, 4'b0000, 1'b1, 4'b0000);
        reset = 1'b0;
        checkOutput("rst_after", 4'b0010, 1'b0, 4'b0000);

`ifdef UMI_ARB_STARVE_EN
        $display("[TB] starvation override");
        doReset();
        bus.weights = 16'h111F;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1001, 4'b1111, 1'b1, 4'b0000);
            checkOutput($sformatf("stv_wait%0d", i), 4'b0001, 1'b0, 4'b0000);
        end
        applyStimulus(4'b1001, 4'b1111, 1'b1, 4'b0000);
        checkOutput("stv_win", 4'b1000, 1'b0, 4'b1000);
        applyStimulus(4'b1001, 4'b1111, 1'b1, 4'b0000);
        checkOutput("stv_clear", 4'b0001, 1'b0, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/umi_wrr_arbiter.md
Name: umi_wrr_arbiter

Overview:
- Packet-aware weighted round-robin arbiter that sequences N UMI requesters onto one shared output, e.g. the select/ready control of an N:1 UMI mux.
- Grants one requester at a time and holds the grant until that requester's end-of-message beat transfers, so multi-beat packets are never interleaved.
- Per-requester weights set how many consecutive packets a requester may send before priority rotates.

Parameters:
- N, 4, number of requesters
- WW, 4, width of each weight field
- SW, 8, width of starvation wait counters (used only with the optional feature)
- STARVE_LIMIT, 64, wait count at which a requester is flagged starved

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- weights  input  N*WW  per-requester packet quota; field i is weights[i*WW+:WW]; value 0 is treated as 1
- arbmask  input  N  1 = requester excluded from new arbitration
- req_valid  input  N  requester i has a beat pending
- req_eom  input  N  end-of-message flag of requester i's current beat (UMI cmd bit 22, extracted by the parent)
- out_ready  input  1  downstream accepts a beat this cycle
- grant  output  N  one-hot or zero; selects the requester driving the output
- sel  output  $clog2(N)  binary index of grant; 0 when grant is 0
- busy  output  1  1 while in LOCKED
- starve  output  N  starvation flags (optional feature)

Behaviour:
- Reset values (synchronous): state IDLE, ptr=0, pkt_cnt=0, lock_sel=0, all wait counters 0. Outputs after reset: grant=0 unless a request is pending, busy=0, starve=0.
- grant and sel are combinational from registered state and current inputs. Grant latency is 0 cycles.
- A transfer occurs in a cycle where grant[i] & req_valid[i] & out_ready.
- IDLE:
  - Candidates are req_valid & ~arbmask.
  - grant goes to the first candidate found searching from index ptr upward, wrapping modulo N.
  - If there are no candidates, grant=0.
  - A transfer with req_eom[i]=0 moves to LOCKED with lock_sel=i.
  - A transfer with req_eom[i]=1 completes a single-beat packet; apply the packet-completion rule and stay in IDLE.
- LOCKED:
  - grant = onehot(lock_sel) regardless of arbmask, even if req_valid[lock_sel] is 0. Bubbles hold the lock.
  - A transfer with req_eom=1 applies the packet-completion rule and returns to IDLE.
- Packet-completion rule for requester i:
  - If pkt_cnt+1 >= max(weights[i],1): ptr=(i+1) mod N, pkt_cnt=0.
  - Otherwise: ptr=i, pkt_cnt=pkt_cnt+1.
  - weights are sampled only at packet completion, so mid-packet weight changes take effect on the next completion.
- If the winner in IDLE differs from the previous ptr holder, pkt_cnt is cleared when that packet starts (quota is per contiguous run).
- out_ready=0 leaves all state unchanged, and grant stays stable.
- arbmask asserted on the locked requester has no effect until its EOM.
- Reset asserted mid-packet returns to IDLE immediately. The partial packet is abandoned, and the parent flushes it.
- All-masked or no requests in IDLE: grant=0, state unchanged.
- N=1: ptr is constant 0, and sel is 1 bit wide (minimum width 1).

Optional Feature:
- Macro: UMI_ARB_STARVE_EN.
- Defined:
  - Per requester, a SW-bit saturating wait counter increments each cycle that req_valid[i] & ~arbmask[i] & ~grant[i].
  - The counter clears on any transfer by i.
  - starve[i] = (counter >= STARVE_LIMIT).
  - In IDLE, if any starve bit is set, the lowest-index starved candidate wins, overriding ptr. The packet-completion rule still applies afterwards.
- Undefined: starve is tied to 0, no counters are instantiated, and arbitration is pure WRR.

Test Plan:
- Single-beat rotation: N=4, weights all 1, all req_valid=1, req_eom=1, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles.
- Weighting: weights={1,1,1,3} (req3..req0), all requesting single-beat packets -> per 6 transfers, req0 gets 3 consecutive grants, then req1, req2 and req3 get 1 each.
- Packet lock: req0 sends a 4-beat packet (eom on beat 4) with req1 valid throughout, plus a 2-cycle out_ready=0 stall and a 1-cycle req_valid[0]=0 bubble mid-packet -> grant=0001 for every cycle until the beat-4 transfer, busy=1 across the packet, req1 granted the next cycle.
- Mask: arbmask=0001 asserted mid-packet of req0 -> req0 finishes its packet; thereafter req0 is never granted while masked, and requesters 1-3 rotate.
- Reset mid-packet: reset pulsed on beat 2 of a 3-beat req2 packet, with req1 valid -> next cycle busy=0 and grant=0010 (ptr=0, first candidate at or above ptr).
- With UMI_ARB_STARVE_EN, STARVE_LIMIT=8, weights[0]=15, req0 and req3 both valid, req0 sending continuous single-beat packets -> starve[3] rises after 8 waiting cycles and req3 is granted in the following IDLE arbitration.
